// File: rtl/dpwm_multicanal.sv
// N-channel digital PWM with button editing of duty, prescaler and selected channel.
// Optional macro DPWM_FASE_EN phase-staggers the channels by 1/N_CH of a period.
module dpwm_multicanal #(
    parameter int N_CH    = 4,
    parameter int RES     = 10,
    parameter int PRESC_W = 8,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               aumentar,
    input  logic               disminuir,
    input  logic               seleccion,
    output logic [N_CH-1:0]    pwm,
    output logic [1:0]         modo,
    output logic [CH_W-1:0]    canal_sel,
    output logic [RES-1:0]     duty_sel,
    output logic [PRESC_W-1:0] presc,
    output logic               fin_periodo
);

    typedef enum logic [1:0] {
        M_DUTY  = 2'd0,
        M_FREC  = 2'd1,
        M_CANAL = 2'd2
    } mode_t;

    localparam logic [RES-1:0]     DUTY_MAX   = '1;
    localparam logic [PRESC_W-1:0] PRESC_MAX  = '1;
    localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(N_CH - 1);
    localparam int                 PHASE_STEP = (1 << RES) / N_CH;

    logic aum_q, dis_q, sel_q;
    logic up_ev, dn_ev, sel_ev, up, dn;

    mode_t state, state_nxt;

    logic [RES-1:0]     shadow     [N_CH];
    logic [RES-1:0]     shadow_nxt [N_CH];
    logic [RES-1:0]     active     [N_CH];
    logic [RES-1:0]     cmp        [N_CH];
    logic [PRESC_W-1:0] presc_nxt;
    logic [CH_W-1:0]    canal_nxt;

    logic [PRESC_W-1:0] div;
    logic [RES-1:0]     cnt;
    logic               tick, wrap;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aum_q <= 1'b0;
            dis_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            aum_q <= aumentar;
            dis_q <= disminuir;
            sel_q <= seleccion;
        end
    end

    assign up_ev  = aumentar  & ~aum_q;
    assign dn_ev  = disminuir & ~dis_q;
    assign sel_ev = seleccion & ~sel_q;
    // Opposing presses in the same cycle cancel each other out.
    assign up     = up_ev & ~dn_ev;
    assign dn     = dn_ev & ~up_ev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= M_DUTY;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (sel_ev) begin
            case (state)
                M_DUTY:  state_nxt = M_FREC;
                M_FREC:  state_nxt = M_CANAL;
                default: state_nxt = M_DUTY;
            endcase
        end
    end

    always_comb begin
        modo = state;
    end

    // Edits act on the mode held before any simultaneous seleccion event.
    always_comb begin
        shadow_nxt = shadow;
        presc_nxt  = presc;
        canal_nxt  = canal_sel;
        case (state)
            M_DUTY: begin
                if (up && shadow[canal_sel] != DUTY_MAX)
                    shadow_nxt[canal_sel] = shadow[canal_sel] + 1'b1;
                else if (dn && shadow[canal_sel] != '0)
                    shadow_nxt[canal_sel] = shadow[canal_sel] - 1'b1;
            end
            M_FREC: begin
                if (up && presc != PRESC_MAX)
                    presc_nxt = presc + 1'b1;
                else if (dn && presc != '0)
                    presc_nxt = presc - 1'b1;
            end
            M_CANAL: begin
                if (up)
                    canal_nxt = (canal_sel == CH_LAST) ? '0 : canal_sel + 1'b1;
                else if (dn)
                    canal_nxt = (canal_sel == '0) ? CH_LAST : canal_sel - 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the duty arrays are small flop banks, not RAM, so they reset like any register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            presc     <= '0;
            canal_sel <= '0;
        end else begin
            shadow    <= shadow_nxt;
            presc     <= presc_nxt;
            canal_sel <= canal_nxt;
            if (wrap) active <= shadow_nxt;
        end
    end

    assign duty_sel = shadow[canal_sel];

    // Compare with >= so a prescaler lowered below div reloads on the next cycle.
    assign tick        = (div >= presc);
    assign wrap        = tick && (cnt == DUTY_MAX);
    assign fin_periodo = wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            cnt <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
`ifdef DPWM_FASE_EN
            cmp[i] = cnt + RES'(i * PHASE_STEP);
`else
            cmp[i] = cnt;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                pwm[i] <= (cmp[i] < active[i]);
        end
    end

endmodule

// File: tb/tb_dpwm_multicanal.sv
// Directed self-checking bench for dpwm_multicanal (N_CH=4, RES=4, PRESC_W=3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dpwm_multicanal;

    logic       clk = 1'b0;
    logic       reset;
    logic       aumentar, disminuir, seleccion;
    logic [3:0] pwm;
    logic [1:0] modo;
    logic [1:0] canal_sel;
    logic [3:0] duty_sel;
    logic [2:0] presc;
    logic       fin_periodo;

    int checks   = 0;
    int failures = 0;
    int cyc;

    logic [3:0] pw_log [16];

    dpwm_multicanal #(.N_CH(4), .RES(4), .PRESC_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .aumentar    (aumentar),
        .disminuir   (disminuir),
        .seleccion   (seleccion),
        .pwm         (pwm),
        .modo        (modo),
        .canal_sel   (canal_sel),
        .duty_sel    (duty_sel),
        .presc       (presc),
        .fin_periodo (fin_periodo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        @(negedge clk);
        aumentar  = u;
        disminuir = d;
        seleccion = s;
        @(negedge clk);
        aumentar  = 1'b0;
        disminuir = 1'b0;
        seleccion = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Returns on the falling edge where fin_periodo is high.
    task automatic wait_fin(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fin_periodo && n < 400);
        check({tag, "_fin_seen"}, 32'(fin_periodo), 32'd1);
    endtask

    task automatic measure_period(output int cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fin_periodo && n < 400);
        cycles = n;
    endtask

    // Call one falling edge after the wrap: sample k shows pwm for cnt==k.
    task automatic sample16();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            pw_log[k] = pwm;
        end
    endtask

    function automatic int count_hi(input int ch);
        int c = 0;
        for (int k = 0; k < 16; k++)
            if (pw_log[k][ch]) c++;
        return c;
    endfunction

    function automatic int first_hi(input int ch);
        for (int k = 0; k < 16; k++)
            if (pw_log[k][ch]) return k;
        return 99;
    endfunction

    initial begin
        reset     = 1'b0;
        aumentar  = 1'b0;
        disminuir = 1'b0;
        seleccion = 1'b0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            aumentar  = i[0];
            disminuir = ~i[0];
            seleccion = i[1];
        end
        check("rst_pwm",       32'(pwm),         32'd0);
        check("rst_modo",      32'(modo),        32'd0);
        check("rst_canal",     32'(canal_sel),   32'd0);
        check("rst_duty",      32'(duty_sel),    32'd0);
        check("rst_presc",     32'(presc),       32'd0);
        check("rst_fin",       32'(fin_periodo), 32'd0);
        @(negedge clk);
        aumentar  = 1'b0;
        disminuir = 1'b0;
        seleccion = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("idle_pwm", 32'(pwm), 32'd0);
        end

        // Duty edit, pwm width and saturation.
        repeat (5) press(1, 0, 0);
        check("duty5", 32'(duty_sel), 32'd5);
        wait_fin("duty5");
        @(negedge clk);
        sample16();
        check("duty5_ch0_hi",    32'(count_hi(0)), 32'd5);
        check("duty5_ch0_first", 32'(first_hi(0)), 32'd0);
        check("duty5_others",    32'(count_hi(1) + count_hi(2) + count_hi(3)), 32'd0);
        repeat (20) press(1, 0, 0);
        check("duty_sat_hi", 32'(duty_sel), 32'd15);
        wait_fin("duty15");
        @(negedge clk);
        sample16();
        check("duty15_ch0_hi", 32'(count_hi(0)), 32'd15);
        repeat (20) press(0, 1, 0);
        check("duty_sat_lo", 32'(duty_sel), 32'd0);

        // Mode cycle.
        press(0, 0, 1);
        check("modo_frec",  32'(modo), 32'd1);
        press(0, 0, 1);
        check("modo_canal", 32'(modo), 32'd2);
        press(0, 0, 1);
        check("modo_duty",  32'(modo), 32'd0);

        // Simultaneous events.
        repeat (3) press(1, 0, 0);
        check("duty3", 32'(duty_sel), 32'd3);
        press(1, 1, 0);
        check("updn_same_cycle", 32'(duty_sel), 32'd3);
        press(1, 0, 1);
        check("up_sel_duty", 32'(duty_sel), 32'd4);
        check("up_sel_modo", 32'(modo),     32'd1);
        press(0, 0, 1);
        press(0, 0, 1);
        check("modo_back", 32'(modo), 32'd0);

        // Prescaler and period length.
        do_reset();
        check("rst2_duty", 32'(duty_sel), 32'd0);
        press(0, 0, 1);
        repeat (2) press(1, 0, 0);
        check("presc2", 32'(presc), 32'd2);
        wait_fin("presc2");
        measure_period(cyc);
        check("period_presc2", 32'(cyc), 32'd48);
        repeat (10) press(1, 0, 0);
        check("presc_sat_hi", 32'(presc), 32'd7);
        wait_fin("presc7");
        measure_period(cyc);
        check("period_presc7", 32'(cyc), 32'd128);
        repeat (8) press(0, 1, 0);
        check("presc_sat_lo", 32'(presc), 32'd0);

        // Channel wrap and single-channel output.
        do_reset();
        press(0, 0, 1);
        press(0, 0, 1);
        check("modo_canal2", 32'(modo), 32'd2);
        press(0, 1, 0);
        check("canal_wrap_dn", 32'(canal_sel), 32'd3);
        press(1, 0, 0);
        check("canal_wrap_up", 32'(canal_sel), 32'd0);
        press(0, 1, 0);
        press(0, 0, 1);
        check("canal3_duty_mode", 32'(modo), 32'd0);
        repeat (8) press(1, 0, 0);
        check("ch3_duty8", 32'(duty_sel), 32'd8);
        wait_fin("ch3");
        @(negedge clk);
        sample16();
        check("ch3_hi",     32'(count_hi(3)), 32'd8);
        check("ch3_others", 32'(count_hi(0) + count_hi(1) + count_hi(2)), 32'd0);

        // Mid-period edit keeps the running width.
        wait_fin("glitch");
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            pw_log[k] = pwm;
            if (k == 2) aumentar = 1'b1;
            if (k == 3) aumentar = 1'b0;
        end
        check("glitch_duty9",   32'(duty_sel),    32'd9);
        check("glitch_old_hi",  32'(count_hi(3)), 32'd8);
        wait_fin("glitch_next");
        @(negedge clk);
        sample16();
        check("glitch_new_hi",  32'(count_hi(3)), 32'd9);

        // Edit on the wrap cycle is loaded at once.
        wait_fin("wrap_edit");
        aumentar = 1'b1;
        @(negedge clk);
        aumentar = 1'b0;
        sample16();
        check("wrap_edit_duty", 32'(duty_sel),    32'd10);
        check("wrap_edit_hi",   32'(count_hi(3)), 32'd10);

        // Asynchronous reset mid-period.
        wait_fin("async");
        repeat (3) @(negedge clk);
        check("async_pre_pwm3", 32'(pwm[3]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_pwm",   32'(pwm),       32'd0);
        check("async_duty",  32'(duty_sel),  32'd0);
        check("async_canal", 32'(canal_sel), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Four channels at duty 4: alignment.
        repeat (4) press(1, 0, 0);
        for (int ch = 1; ch < 4; ch++) begin
            press(0, 0, 1);
            press(0, 0, 1);
            press(1, 0, 0);
            press(0, 0, 1);
            repeat (4) press(1, 0, 0);
        end
        check("align_canal", 32'(canal_sel), 32'd3);
        check("align_duty",  32'(duty_sel),  32'd4);
        wait_fin("align");
        @(negedge clk);
        sample16();
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("align_hi_ch%0d", ch), 32'(count_hi(ch)), 32'd4);
`ifdef DPWM_FASE_EN
            check($sformatf("phase_rise_ch%0d", ch), 32'(first_hi(ch)), 32'((16 - 4 * ch) % 16));
`else
            check($sformatf("align_rise_ch%0d", ch), 32'(first_hi(ch)), 32'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
